// File: rtl/risc_ctrl_pkg.sv
// Shared types and encodings for the Simple RISC Machine control FSM.
// Holds the state enum plus mem_cmd, nsel, vsel, opcode and op field encodings.
// No logic lives here apart from one small state-classification helper.
package risc_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RESET, ST_IF, ST_UPD_PC, ST_DECODE, ST_MOV_IMM, ST_GET_B, ST_EXEC,
    ST_WB, ST_L_ADDR, ST_S_ADDR, ST_L_LA, ST_S_LA, ST_L_RD, ST_S_GETD,
    ST_S_PASS, ST_S_WR, ST_LINK, ST_BR, ST_BX, ST_HALT, ST_FAULT
  } state_t;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WR   = 2'b01;
  localparam logic [1:0] MEM_RD   = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;  // BL / BLX / BX group
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_BX      = 2'b00;
  localparam logic [1:0] OP_BLX     = 2'b10;
  localparam logic [1:0] OP_BL      = 2'b11;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_wait(state_t s);
    return (s == ST_IF) || (s == ST_L_RD) || (s == ST_S_WR);
  endfunction

endpackage

// File: rtl/risc_ctrl_if.sv
// Control bundle between the FSM (master) and decoder/datapath/memory (slave).
// Purely structural; no latency.
// Handshake is mem_ready from the memory side; the FSM holds its request until it arrives.
import risc_ctrl_pkg::*;

interface risc_ctrl_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic       cond_taken;
  logic       resume;

  logic       loada, loadb, loadc, loads;
  logic       load_ir, load_pc, load_bpc, load_addr;
  logic       asel, bsel, addr_sel, reset_pc;
  logic [1:0] mem_cmd;
  logic [1:0] vsel;
  logic [2:0] nsel;
  logic       write, w, fault;

  modport master (
    input  opcode, op, mem_ready, cond_taken, resume,
    output loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr,
           asel, bsel, addr_sel, reset_pc, mem_cmd, vsel, nsel, write, w, fault
  );

  modport slave (
    output opcode, op, mem_ready, cond_taken, resume,
    input  loada, loadb, loadc, loads, load_ir, load_pc, load_bpc, load_addr,
           asel, bsel, addr_sel, reset_pc, mem_cmd, vsel, nsel, write, w, fault
  );
endinterface

// File: rtl/risc_ctrl_timeout.sv
// Memory wait counter: counts wait cycles and flags when MEM_TIMEOUT is reached.
// Expired is combinational from the count; count saturates at MEM_TIMEOUT.
// Clear has priority over enable; no backpressure of its own.
module risc_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TMO_W-1:0] r_cnt;

  assign o_expired = (r_cnt == TMO_W'(MEM_TIMEOUT));

  // Wait-cycle counter, cleared on every state change, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_en && !o_expired)  r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Control FSM for the Simple RISC Machine: decodes state into datapath/memory controls.
// Moore outputs except load_ir and LDR writeback, which are gated by mem_ready in the same cycle.
// Memory states hold until mem_ready; RISC_CTRL_TIMEOUT_EN bounds that wait and traps to FAULT.
import risc_ctrl_pkg::*;

module risc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  risc_ctrl_if.master   ctrl
);

  state_t r_state, w_next;
  logic   r_link_bx;      // LINK continues into BX (BLX) rather than BR (BL)
  logic   w_tmo_expired;

  if (MEM_TIMEOUT < 1 || TMO_W < $clog2(MEM_TIMEOUT + 1)) begin : g_bad_cfg
    $error("risc_ctrl_fsm: MEM_TIMEOUT must be >= 1 and TMO_W wide enough to hold it");
  end

`ifdef RISC_CTRL_TIMEOUT_EN
  logic w_tmo_clr, w_tmo_en;
  assign w_tmo_clr = (w_next != r_state);
  assign w_tmo_en  = is_mem_wait(r_state) && !ctrl.mem_ready;

  risc_ctrl_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  // State register; reset enters RESET asynchronously, aborting any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  // Remember in DECODE whether a LINK belongs to BLX so LINK need not read op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_link_bx <= 1'b0;
    else if (r_state == ST_DECODE)  r_link_bx <= (ctrl.op == OP_BLX);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next         = r_state;
    ctrl.loada     = 1'b0;
    ctrl.loadb     = 1'b0;
    ctrl.loadc     = 1'b0;
    ctrl.loads     = 1'b0;
    ctrl.load_ir   = 1'b0;
    ctrl.load_pc   = 1'b0;
    ctrl.load_bpc  = 1'b0;
    ctrl.load_addr = 1'b0;
    ctrl.asel      = 1'b0;
    ctrl.bsel      = 1'b0;
    ctrl.addr_sel  = 1'b0;
    ctrl.reset_pc  = 1'b0;
    ctrl.mem_cmd   = MEM_NONE;
    ctrl.vsel      = VSEL_C;
    ctrl.nsel      = 3'b000;
    ctrl.write     = 1'b0;
    ctrl.w         = 1'b0;
    ctrl.fault     = 1'b0;

    case (r_state)
      ST_RESET: begin
        ctrl.reset_pc = 1'b1;
        ctrl.load_pc  = 1'b1;
        w_next        = ST_IF;
      end
      ST_IF: begin
        ctrl.addr_sel = 1'b1;
        ctrl.mem_cmd  = MEM_RD;
        ctrl.load_ir  = ctrl.mem_ready;
        if (ctrl.mem_ready)   w_next = ST_UPD_PC;
        else if (w_tmo_expired) w_next = ST_FAULT;
      end
      ST_UPD_PC: begin
        ctrl.load_pc = 1'b1;
        w_next       = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
        w_next     = ST_FAULT;
        case (ctrl.opcode)
          OPC_MOV: begin
            if (ctrl.op == OP_MOV_IMM)      w_next = ST_MOV_IMM;
            else if (ctrl.op == OP_MOV_REG) w_next = ST_GET_B;
          end
          OPC_ALU:  w_next = ST_GET_B;
          OPC_LDR:  if (ctrl.op == OP_MEM) w_next = ST_L_ADDR;
          OPC_STR:  if (ctrl.op == OP_MEM) w_next = ST_S_ADDR;
          OPC_B:    w_next = ctrl.cond_taken ? ST_BR : ST_IF;
          OPC_BL: begin
            if (ctrl.op == OP_BL || ctrl.op == OP_BLX) w_next = ST_LINK;
            else if (ctrl.op == OP_BX)                 w_next = ST_BX;
          end
          OPC_HALT: w_next = ST_HALT;
          default:  w_next = ST_FAULT;
        endcase
      end
      ST_MOV_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
        w_next     = ST_IF;
      end
      ST_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
        w_next     = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctrl.opcode == OPC_ALU && ctrl.op == OP_CMP) begin
          ctrl.loads = 1'b1;
          w_next     = ST_IF;
        end else begin
          ctrl.loadc = 1'b1;
          ctrl.asel  = (ctrl.opcode == OPC_MOV);
          w_next     = ST_WB;
        end
      end
      ST_WB: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
        w_next     = ST_IF;
      end
      ST_L_ADDR, ST_S_ADDR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
        w_next     = (r_state == ST_L_ADDR) ? ST_L_LA : ST_S_LA;
      end
      ST_L_LA, ST_S_LA: begin
        ctrl.load_addr = 1'b1;
        w_next         = (r_state == ST_L_LA) ? ST_L_RD : ST_S_GETD;
      end
      ST_L_RD: begin
        ctrl.mem_cmd = MEM_RD;
        if (ctrl.mem_ready) begin
          ctrl.nsel  = NSEL_RD;
          ctrl.vsel  = VSEL_MDATA;
          ctrl.write = 1'b1;
          w_next     = ST_IF;
        end else if (w_tmo_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_S_GETD: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.loadb = 1'b1;
        w_next     = ST_S_PASS;
      end
      ST_S_PASS: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
        w_next     = ST_S_WR;
      end
      ST_S_WR: begin
        ctrl.mem_cmd = MEM_WR;
        if (ctrl.mem_ready)     w_next = ST_IF;
        else if (w_tmo_expired) w_next = ST_FAULT;
      end
      ST_LINK: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_PC;
        ctrl.write = 1'b1;
        w_next     = r_link_bx ? ST_BX : ST_BR;
      end
      ST_BR: begin
        ctrl.load_bpc = 1'b1;
        ctrl.load_pc  = 1'b1;
        w_next        = ST_IF;
      end
      ST_BX: begin
        ctrl.nsel     = NSEL_RD;
        ctrl.load_bpc = 1'b1;
        ctrl.load_pc  = 1'b1;
        w_next        = ST_IF;
      end
      ST_HALT: begin
        ctrl.w = 1'b1;
        if (ctrl.resume) w_next = ST_IF;
      end
      ST_FAULT: begin
        ctrl.w     = 1'b1;
        ctrl.fault = 1'b1;
      end
      default: w_next = ST_FAULT;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Self-checking bench for risc_ctrl_fsm: per-cycle expected control vectors via a scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Timeout expectations follow RISC_CTRL_TIMEOUT_EN when the bench is built with it.
module tb_risc_ctrl_fsm;
  import risc_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  risc_ctrl_if bus ();

  risc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  // Expected-behaviour labels, one per controller state, defined independently of the RTL.
  typedef enum int {
    X_RESET, X_IF, X_UPD, X_DEC, X_MOVI, X_GETB, X_EXEC_ALU, X_EXEC_MOV, X_EXEC_CMP,
    X_WB, X_ADDR, X_LA, X_LRD, X_SGETD, X_SPASS, X_SWR, X_LINK, X_BR, X_BX, X_HALT, X_FAULT
  } xs_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] sb_q[$];
  string       tag_q[$];

  // Bit layout: loada loadb loadc loads load_ir load_pc load_bpc load_addr asel bsel
  //             addr_sel reset_pc mem_cmd[1:0] vsel[1:0] nsel[2:0] write w fault
  function automatic logic [21:0] obs();
    return {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.load_ir, bus.load_pc,
            bus.load_bpc, bus.load_addr, bus.asel, bus.bsel, bus.addr_sel, bus.reset_pc,
            bus.mem_cmd, bus.vsel, bus.nsel, bus.write, bus.w, bus.fault};
  endfunction

  function automatic logic [21:0] exp_of(xs_t s, logic mr);
    logic [21:0] v;
    v = '0;
    case (s)
      X_RESET:    begin v[10] = 1'b1; v[16] = 1'b1; end
      X_IF:       begin v[11] = 1'b1; v[9:8] = 2'b11; v[17] = mr; end
      X_UPD:      v[16] = 1'b1;
      X_DEC:      begin v[5:3] = 3'b100; v[21] = 1'b1; end
      X_MOVI:     begin v[5:3] = 3'b100; v[7:6] = 2'b10; v[2] = 1'b1; end
      X_GETB:     begin v[5:3] = 3'b001; v[20] = 1'b1; end
      X_EXEC_ALU: v[19] = 1'b1;
      X_EXEC_MOV: begin v[19] = 1'b1; v[13] = 1'b1; end
      X_EXEC_CMP: v[18] = 1'b1;
      X_WB:       begin v[5:3] = 3'b010; v[2] = 1'b1; end
      X_ADDR:     begin v[12] = 1'b1; v[19] = 1'b1; end
      X_LA:       v[14] = 1'b1;
      X_LRD:      begin
                    v[9:8] = 2'b11;
                    if (mr) begin v[5:3] = 3'b010; v[7:6] = 2'b11; v[2] = 1'b1; end
                  end
      X_SGETD:    begin v[5:3] = 3'b010; v[20] = 1'b1; end
      X_SPASS:    begin v[13] = 1'b1; v[19] = 1'b1; end
      X_SWR:      v[9:8] = 2'b01;
      X_LINK:     begin v[5:3] = 3'b100; v[7:6] = 2'b01; v[2] = 1'b1; end
      X_BR:       begin v[15] = 1'b1; v[16] = 1'b1; end
      X_BX:       begin v[5:3] = 3'b010; v[15] = 1'b1; v[16] = 1'b1; end
      X_HALT:     v[1] = 1'b1;
      X_FAULT:    begin v[1] = 1'b1; v[0] = 1'b1; end
      default:    v = '1;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: push expectation, sample on the falling edge, advance.
  task automatic cyc(input xs_t s, input string tag);
    sb_q.push_back(exp_of(s, bus.mem_ready));
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), obs(), sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges (checks the asynchronous entry), then release.
  task automatic do_reset();
    reset = 1'b1;
    cyc(X_RESET, "rst_async");
    reset = 1'b0;
    cyc(X_RESET, "rst_release");
  endtask

  task automatic fetch(input int wait_n, input logic [2:0] opc, input logic [1:0] op_f,
                       input logic cond);
    bus.opcode = opc;
    bus.op = op_f;
    bus.cond_taken = cond;
    for (int i = 0; i < wait_n; i++) begin
      bus.mem_ready = 1'b0;
      cyc(X_IF, "if_wait");
    end
    bus.mem_ready = 1'b1;
    cyc(X_IF, "if_done");
    cyc(X_UPD, "upd_pc");
    cyc(X_DEC, "decode");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode = 3'b000;
    bus.op = 2'b00;
    bus.mem_ready = 1'b1;
    bus.cond_taken = 1'b0;
    bus.resume = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // MOV immediate with a single-cycle fetch
    fetch(0, OPC_MOV, OP_MOV_IMM, 1'b0);
    cyc(X_MOVI, "mov_imm");
    // ADD with a 4-cycle fetch wait
    fetch(4, OPC_ALU, 2'b00, 1'b0);
    cyc(X_GETB, "add_getb"); cyc(X_EXEC_ALU, "add_exec"); cyc(X_WB, "add_wb");
    // CMP
    fetch(0, OPC_ALU, OP_CMP, 1'b0);
    cyc(X_GETB, "cmp_getb"); cyc(X_EXEC_CMP, "cmp_exec");
    // MOV register
    fetch(1, OPC_MOV, OP_MOV_REG, 1'b0);
    cyc(X_GETB, "movr_getb"); cyc(X_EXEC_MOV, "movr_exec"); cyc(X_WB, "movr_wb");
    // Branch untaken, then taken
    fetch(0, OPC_B, 2'b00, 1'b0);
    fetch(0, OPC_B, 2'b00, 1'b1);
    cyc(X_BR, "b_taken");
    // BLX, BL, BX
    fetch(0, OPC_BL, OP_BLX, 1'b0);
    cyc(X_LINK, "blx_link"); cyc(X_BX, "blx_bx");
    fetch(0, OPC_BL, OP_BL, 1'b0);
    cyc(X_LINK, "bl_link"); cyc(X_BR, "bl_br");
    fetch(0, OPC_BL, OP_BX, 1'b0);
    cyc(X_BX, "bx");
    // LDR with two wait cycles; mem_ready high in non-memory states is ignored
    fetch(0, OPC_LDR, OP_MEM, 1'b0);
    cyc(X_ADDR, "ldr_addr"); cyc(X_LA, "ldr_la");
    bus.mem_ready = 1'b0;
    cyc(X_LRD, "ldr_wait"); cyc(X_LRD, "ldr_wait");
    bus.mem_ready = 1'b1;
    cyc(X_LRD, "ldr_done");
    // HALT and resume (mem_ready high throughout has no effect)
    fetch(0, OPC_HALT, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(X_HALT, "halt_hold");
    bus.resume = 1'b1;
    cyc(X_HALT, "halt_resume");
    bus.resume = 1'b0;
    // Undefined opcode 000 traps; resume does not leave FAULT
    fetch(0, 3'b000, 2'b00, 1'b0);
    bus.resume = 1'b1;
    for (int i = 0; i < 3; i++) cyc(X_FAULT, "fault_hold");
    bus.resume = 1'b0;
    do_reset();
    // Undefined op within a defined opcode also traps
    fetch(0, OPC_LDR, 2'b01, 1'b0);
    cyc(X_FAULT, "fault_ldr_op");
    do_reset();
    // Reset during a fetch wait aborts the read at once
    bus.mem_ready = 1'b0;
    cyc(X_IF, "if_wait"); cyc(X_IF, "if_wait");
    do_reset();
    // STR with a 20-cycle stalled write
    fetch(0, OPC_STR, OP_MEM, 1'b0);
    cyc(X_ADDR, "str_addr"); cyc(X_LA, "str_la");
    cyc(X_SGETD, "str_getd"); cyc(X_SPASS, "str_pass");
    bus.mem_ready = 1'b0;
`ifdef RISC_CTRL_TIMEOUT_EN
    for (int i = 0; i <= MEM_TIMEOUT; i++) cyc(X_SWR, "str_wait");
    for (int i = 0; i < 4; i++) cyc(X_FAULT, "str_timeout");
`else
    for (int i = 0; i < 20; i++) cyc(X_SWR, "str_wait");
    bus.mem_ready = 1'b1;
    cyc(X_SWR, "str_done");
    cyc(X_IF, "str_after");
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_fsm.md
# risc_ctrl_fsm

- Parametrised control FSM for the Simple RISC Machine datapath.
- Successor to the fixed-latency controller:
  - Memory accesses use a ready handshake with variable latency.
  - Branches are conditional via an external condition input.
  - BL, BX and BLX all decode reachably.
  - HALT can be left through a resume input.
  - Undefined opcodes trap to a FAULT state.
- Sits between the instruction register decoder, datapath/register file, PC/address logic and the memory interface.

## Interface

Parameters:
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready (used only with the timeout macro).
- TMO_W, $clog2(MEM_TIMEOUT+1), width of the timeout counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  3  instruction opcode field.
- op  in  2  instruction op field.
- mem_ready  in  1  memory completed the current read/write this cycle.
- cond_taken  in  1  branch condition true (from status flags).
- resume  in  1  leave HALT.
- loada, loadb, loadc, loads  out  1 each  datapath register loads.
- load_ir, load_pc, load_bpc, load_addr  out  1 each  IR/PC/branch-PC/address-register loads.
- asel, bsel  out  1 each  ALU operand selects.
- addr_sel  out  1  1 selects PC as memory address, 0 selects the address register.
- reset_pc  out  1  PC loads 0.
- mem_cmd  out  2  00 none, 01 write, 11 read.
- vsel  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata.
- nsel  out  3  register select, one-hot: 100 Rn, 010 Rd, 001 Rm.
- write  out  1  register file write.
- w  out  1  CPU waiting (HALT/FAULT).
- fault  out  1  in FAULT.

## Operation

- Outputs are decoded from state. Any output not listed for a state is 0.
- load_ir and the LDR writeback are additionally gated by mem_ready.
- States and transitions:
  - RESET: reset_pc=1, load_pc=1 → IF.
  - IF: addr_sel=1, mem_cmd=11, load_ir=mem_ready. Holds until mem_ready, then → UPD_PC.
  - UPD_PC: load_pc=1 → DECODE.
  - DECODE: nsel=100, loada=1. Dispatch:
    - 110/10 → MOV_IMM.
    - 110/00 → GET_B.
    - 101/xx → GET_B.
    - 011/00 → L_ADDR.
    - 100/00 → S_ADDR.
    - 001 → BR if cond_taken, else IF.
    - 010/11 → LINK (BL).
    - 010/10 → LINK (BLX).
    - 010/00 → BX.
    - 111 → HALT.
    - anything else → FAULT.
  - MOV_IMM: nsel=100, vsel=10, write → IF.
  - GET_B: nsel=001, loadb → EXEC.
  - EXEC: loadc. asel=1 for MOV (opcode 110). For CMP (101/01): loads=1, loadc=0, → IF. Otherwise → WB.
  - WB: nsel=010, vsel=00, write → IF.
  - L_ADDR / S_ADDR: bsel=1, loadc → L_LA / S_LA.
  - L_LA: load_addr → L_RD. S_LA: load_addr → S_GETD.
  - L_RD: mem_cmd=11, addr_sel=0. When mem_ready: nsel=010, vsel=11, write, → IF.
  - S_GETD: nsel=010, loadb → S_PASS.
  - S_PASS: asel=1, loadc → S_WR.
  - S_WR: mem_cmd=01, addr_sel=0. Holds until mem_ready → IF.
  - LINK: nsel=100, vsel=01, write. BL → BR, BLX → BX.
  - BR: load_bpc=1, load_pc=1 → IF.
  - BX: nsel=010, load_bpc=1, load_pc=1 → IF.
  - HALT: w=1. Stays until resume=1, then → IF.
  - FAULT: w=1, fault=1. Left only by reset.
- opcode and op are sampled only in DECODE and EXEC. They must be stable from UPD_PC through the end of the instruction.

## Timing

- Reset: asynchronous entry to RESET. Outputs are reset_pc=1, load_pc=1, all other outputs 0.
- Reset mid-access aborts the access immediately, and mem_cmd drops to 00 asynchronously.
- Fetch takes 1+N cycles, where N is the number of cycles before mem_ready. mem_ready high in the first IF cycle gives a 1-cycle fetch.
- Instruction lengths, excluding fetch/UPD_PC/DECODE:
  - MOV_IMM: 1 cycle.
  - ALU: 3 cycles (CMP 2).
  - LDR: 3 cycles plus memory wait.
  - STR: 5 cycles plus memory wait.
  - Taken B: 1 cycle. Untaken B: 0 cycles.
  - BL/BLX: 2 cycles.
  - BX: 1 cycle.
- mem_ready outside IF/L_RD/S_WR is ignored.
- resume and mem_ready in the same cycle have no interaction.

## Configuration

- Macro: RISC_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to IF, L_RD and S_WR, and increments each wait cycle.
  - If the count reaches MEM_TIMEOUT with mem_ready still low, the FSM goes to FAULT next cycle.
  - mem_ready arriving in that same cycle wins, and the access completes normally.
- Undefined:
  - No counter. Waits are unbounded.
  - FAULT is reachable only via an undefined opcode.

## Structure

- Package risc_ctrl_pkg holds:
  - The state enum.
  - mem_cmd constants (MEM_NONE, MEM_WR, MEM_RD).
  - nsel constants (NSEL_RN, NSEL_RD, NSEL_RM).
  - vsel constants.
  - Opcode constants.
- Sub-module risc_ctrl_timeout holds the wait counter, with clear, enable and expired ports. It is instantiated only under RISC_CTRL_TIMEOUT_EN.

## Test plan

- Reset, mem_ready tied 1 → RESET, IF, UPD_PC, DECODE on consecutive cycles. load_ir high exactly one cycle.
- mem_ready delayed 4 cycles during fetch → IF held 5 cycles, mem_cmd=11 throughout, load_ir only in the 5th cycle.
- opcode=001 with cond_taken=0 → DECODE→IF, load_pc never high. With cond_taken=1 → BR with load_bpc=load_pc=1.
- opcode=010, op=10 (BLX) → LINK (nsel=100, vsel=01, write=1), then BX (nsel=010, load_pc=1), then IF.
- STR with mem_ready=0 for 20 cycles and MEM_TIMEOUT=15, macro defined → FAULT, fault=1, w=1. Without the macro, the FSM stays in S_WR until mem_ready, then → IF.
- opcode=111 → HALT, w=1 held. resume pulse → IF next cycle. opcode=000 → FAULT, cleared only by reset.
